// File: rtl/maquina_preparo.sv
// Brew sequencer: qualifies a start request against sensor status, then heats and extracts.
// Optional pre-infusion pulse between heating and extraction is enabled with `define PREINFUSAO_EN.
module maquina_preparo #(
    parameter int unsigned T_VERIFICA = 16,
    parameter int unsigned T_AQUECE   = 8,
    parameter int unsigned T_EXPRESSO = 4,
    parameter int unsigned T_LONGO    = 8,
    parameter int unsigned T_DUPLO    = 12,
    parameter int unsigned T_PRE      = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [1:0] TIPO,
    input  logic [1:0] STATUS,
    output logic       AQUECEDOR,
    output logic       BOMBA,
    output logic       OCUPADO,
    output logic       PRONTO,
    output logic       ERRO,
    output logic [3:0] DISPLAY
);

    localparam int unsigned CW = 8;

    // Every counter reload below truncates to CW bits, so out-of-range values are rejected here.
    if (T_VERIFICA < 1 || T_VERIFICA > 255 || T_AQUECE < 1 || T_AQUECE > 255 ||
        T_EXPRESSO < 1 || T_EXPRESSO > 255 || T_LONGO < 1 || T_LONGO > 255 ||
        T_DUPLO < 1 || T_DUPLO > 255 || T_PRE < 1 || T_PRE > 255) begin : g_param_invalido
        $error("maquina_preparo: all timing parameters must be in 1..255");
    end

    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        VERIFICA = 3'd1,
        AQUECE   = 3'd2,
        EXTRAI   = 3'd3,
        FINALIZA = 3'd4,
        FALHA    = 3'd7
`ifdef PREINFUSAO_EN
        , PRE_ON = 3'd5,
        PRE_OFF  = 3'd6
`endif
    } estado_t;

    estado_t        estado, estado_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [1:0]     tipo_q, tipo_n;
    logic [CW-1:0]  carga_extrai;
    logic           fatal;

    assign fatal = (STATUS == 2'b11);

    // Extraction length comes from the drink latched at start, never from the live input.
    always_comb begin
        case (tipo_q)
            2'b01:   carga_extrai = CW'(T_LONGO - 1);
            2'b10:   carga_extrai = CW'(T_DUPLO - 1);
            default: carga_extrai = CW'(T_EXPRESSO - 1);
        endcase
    end

    // Next state: fatal status wins over any counter expiry in the busy states.
    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        tipo_n   = tipo_q;
        case (estado)
            ESPERA: begin
                if (START && (TIPO != 2'b11)) begin
                    estado_n = VERIFICA;
                    cnt_n    = CW'(T_VERIFICA - 1);
                    tipo_n   = TIPO;
                end
            end
            VERIFICA: begin
                if (fatal) begin
                    estado_n = FALHA;
                end else if (STATUS == 2'b10) begin
                    estado_n = AQUECE;
                    cnt_n    = CW'(T_AQUECE - 1);
                end else if (cnt == '0) begin
                    estado_n = FALHA;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            AQUECE: begin
                if (fatal) begin
                    estado_n = FALHA;
                end else if (cnt == '0) begin
`ifdef PREINFUSAO_EN
                    estado_n = PRE_ON;
                    cnt_n    = CW'(T_PRE - 1);
`else
                    estado_n = EXTRAI;
                    cnt_n    = carga_extrai;
`endif
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
`ifdef PREINFUSAO_EN
            PRE_ON: begin
                if (fatal) begin
                    estado_n = FALHA;
                end else if (cnt == '0) begin
                    estado_n = PRE_OFF;
                    cnt_n    = CW'(T_PRE - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            PRE_OFF: begin
                if (fatal) begin
                    estado_n = FALHA;
                end else if (cnt == '0) begin
                    estado_n = EXTRAI;
                    cnt_n    = carga_extrai;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
`endif
            EXTRAI: begin
                if (fatal) begin
                    estado_n = FALHA;
                end else if (cnt == '0) begin
                    estado_n = FINALIZA;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            FINALIZA: estado_n = ESPERA;
            FALHA:    estado_n = FALHA;
            default:  estado_n = ESPERA;
        endcase
    end

    // State, counters and outputs; outputs are decoded from the state being entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado    <= ESPERA;
            cnt       <= '0;
            tipo_q    <= 2'b00;
            AQUECEDOR <= 1'b0;
            BOMBA     <= 1'b0;
            OCUPADO   <= 1'b0;
            PRONTO    <= 1'b0;
            ERRO      <= 1'b0;
            DISPLAY   <= 4'b0000;
        end else begin
            estado    <= estado_n;
            cnt       <= cnt_n;
            tipo_q    <= tipo_n;
            AQUECEDOR <= 1'b0;
            BOMBA     <= 1'b0;
            OCUPADO   <= 1'b1;
            PRONTO    <= 1'b0;
            ERRO      <= 1'b0;
            DISPLAY   <= 4'b0000;
            case (estado_n)
                ESPERA:   OCUPADO <= 1'b0;
                VERIFICA: DISPLAY <= 4'b0100;
                AQUECE: begin
                    AQUECEDOR <= 1'b1;
                    DISPLAY   <= 4'b0001;
                end
`ifdef PREINFUSAO_EN
                PRE_ON: begin
                    AQUECEDOR <= 1'b1;
                    BOMBA     <= 1'b1;
                    DISPLAY   <= 4'b0101;
                end
                PRE_OFF: begin
                    AQUECEDOR <= 1'b1;
                    DISPLAY   <= 4'b0101;
                end
`endif
                EXTRAI: begin
                    AQUECEDOR <= 1'b1;
                    BOMBA     <= 1'b1;
                    DISPLAY   <= 4'b0010;
                end
                FINALIZA: begin
                    PRONTO  <= 1'b1;
                    DISPLAY <= 4'b0011;
                end
                FALHA: begin
                    OCUPADO <= 1'b0;
                    ERRO    <= 1'b1;
                    DISPLAY <= 4'b1111;
                end
                default: OCUPADO <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_maquina_preparo.sv
// Bench for maquina_preparo: expected per-cycle output timelines are built from drink,
// verification wait and abort point, then compared cycle by cycle against the DUT.
module tb_maquina_preparo;

    localparam int unsigned T_VERIFICA = 16;
    localparam int unsigned T_AQUECE   = 8;
    localparam int unsigned T_EXPRESSO = 4;
    localparam int unsigned T_LONGO    = 8;
    localparam int unsigned T_DUPLO    = 12;
    localparam int unsigned T_PRE      = 2;

    // Output vectors {AQUECEDOR, BOMBA, OCUPADO, PRONTO, ERRO, DISPLAY}
    localparam logic [8:0] V_ESP = {5'b00000, 4'b0000};
    localparam logic [8:0] V_VER = {5'b00100, 4'b0100};
    localparam logic [8:0] V_AQU = {5'b10100, 4'b0001};
    localparam logic [8:0] V_PON = {5'b11100, 4'b0101};
    localparam logic [8:0] V_POF = {5'b10100, 4'b0101};
    localparam logic [8:0] V_EXT = {5'b11100, 4'b0010};
    localparam logic [8:0] V_FIN = {5'b00110, 4'b0011};
    localparam logic [8:0] V_FAL = {5'b00001, 4'b1111};

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START;
    logic [1:0] TIPO;
    logic [1:0] STATUS;
    logic       AQUECEDOR, BOMBA, OCUPADO, PRONTO, ERRO;
    logic [3:0] DISPLAY;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    maquina_preparo #(
        .T_VERIFICA(T_VERIFICA), .T_AQUECE(T_AQUECE), .T_EXPRESSO(T_EXPRESSO),
        .T_LONGO(T_LONGO), .T_DUPLO(T_DUPLO), .T_PRE(T_PRE)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .TIPO(TIPO), .STATUS(STATUS),
        .AQUECEDOR(AQUECEDOR), .BOMBA(BOMBA), .OCUPADO(OCUPADO),
        .PRONTO(PRONTO), .ERRO(ERRO), .DISPLAY(DISPLAY)
    );

    always #5 CLK = ~CLK;

    function automatic bit busy(input logic [8:0] v);
        return (v == V_VER) || (v == V_AQU) || (v == V_PON) || (v == V_POF) || (v == V_EXT);
    endfunction

    task automatic chk(input logic [8:0] exp, input string tag);
        logic [8:0] obs;
        obs = {AQUECEDOR, BOMBA, OCUPADO, PRONTO, ERRO, DISPLAY};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic stepc(input logic [8:0] exp, input string tag);
        @(posedge CLK);
        #1;
        cyc++;
        chk(exp, tag);
    endtask

    // Reset pulsed between edges: outputs must clear without a clock.
    task automatic do_reset();
        #2 RST = 1'b1;
        START = 1'b0;
        #1 chk(V_ESP, "rst_async");
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // One brew from ESPERA: w cycles of non-ok status before ok, fatal status driven at index f.
    // smode: 0 START low, 1 START held, 2 START random while the brew runs.
    task automatic run_brew(input logic [1:0] tipo, input int w, input int f,
                            input int smode, output bit falhou);
        logic [8:0] tl[$];
        int tx;
        tx = (tipo == 2'b00) ? int'(T_EXPRESSO) : (tipo == 2'b01) ? int'(T_LONGO) : int'(T_DUPLO);
        if (w >= int'(T_VERIFICA)) begin
            repeat (T_VERIFICA) tl.push_back(V_VER);
            tl.push_back(V_FAL);
        end else begin
            repeat (w + 1) tl.push_back(V_VER);
            repeat (T_AQUECE) tl.push_back(V_AQU);
`ifdef PREINFUSAO_EN
            repeat (T_PRE) tl.push_back(V_PON);
            repeat (T_PRE) tl.push_back(V_POF);
`endif
            repeat (tx) tl.push_back(V_EXT);
            tl.push_back(V_FIN);
            tl.push_back(V_ESP);
        end
        if (f >= 0 && f < int'(tl.size()) && busy(tl[f])) begin
            while (int'(tl.size()) > f + 1) void'(tl.pop_back());
            tl.push_back(V_FAL);
        end

        START  = 1'b1;
        TIPO   = tipo;
        STATUS = 2'($urandom_range(0, 2));
        for (int i = 0; i < int'(tl.size()); i++) begin
            stepc(tl[i], "brew");
            if (i == f)
                STATUS = 2'b11;
            else if (tl[i] == V_VER)
                STATUS = (i < w) ? 2'($urandom_range(0, 1)) : 2'b10;
            else
                STATUS = 2'($urandom_range(0, 2));
            TIPO  = 2'($urandom_range(0, 3));
            START = (smode == 2) ? 1'($urandom_range(0, 1)) : 1'(smode);
            if (tl[i] == V_ESP) START = 1'b0;
        end
        falhou = (tl[tl.size() - 1] == V_FAL);
        if (falhou) begin
            // Fault is sticky: valid requests and any status are ignored.
            repeat (3) begin
                START  = 1'b1;
                TIPO   = 2'($urandom_range(0, 2));
                STATUS = 2'($urandom_range(0, 3));
                stepc(V_FAL, "falha_sticky");
            end
        end
    endtask

    initial begin
        bit falhou;
        int pre;
        pre = 0;
`ifdef PREINFUSAO_EN
        pre = 2 * int'(T_PRE);
`endif
        START  = 1'b0;
        TIPO   = 2'b00;
        STATUS = 2'b00;
        RST    = 1'b1;
        #1 chk(V_ESP, "reset_val");
        START = 1'b1;
        stepc(V_ESP, "reset_held");
        @(negedge CLK);
        RST   = 1'b0;
        START = 1'b0;

        // Espresso with immediate ok status
        run_brew(2'b00, 0, -1, 0, falhou);

        // Invalid drink select is ignored
        START = 1'b1;
        TIPO  = 2'b11;
        stepc(V_ESP, "tipo_invalido");
        stepc(V_ESP, "tipo_invalido");
        START = 1'b0;
        stepc(V_ESP, "ocioso");

        // START held through a long brew, then chained directly into a double
        run_brew(2'b01, 2, -1, 1, falhou);
        run_brew(2'b10, 0, -1, 0, falhou);

        // Ok status on the last verification cycle still proceeds
        run_brew(2'b00, int'(T_VERIFICA) - 1, -1, 2, falhou);

        // Verification timeout
        run_brew(2'b00, 40, -1, 0, falhou);
        do_reset();

        // Fatal on the 5th extraction cycle of a double
        run_brew(2'b10, 0, 1 + int'(T_AQUECE) + pre + 4, 0, falhou);
        do_reset();

        // Fatal beats ok in the same verification cycle
        run_brew(2'b01, 3, 3, 0, falhou);
        do_reset();

        // Async reset during extraction of a long
        START  = 1'b1;
        TIPO   = 2'b01;
        STATUS = 2'b10;
        stepc(V_VER, "rst_ver");
        START = 1'b0;
        TIPO  = 2'b11;
        repeat (T_AQUECE) stepc(V_AQU, "rst_aqu");
`ifdef PREINFUSAO_EN
        repeat (T_PRE) stepc(V_PON, "rst_pon");
        repeat (T_PRE) stepc(V_POF, "rst_pof");
`endif
        repeat (3) stepc(V_EXT, "rst_ext");
        do_reset();
        stepc(V_ESP, "pos_reset");

        // Randomized brews with idle gaps and ignored requests
        for (int n = 0; n < 30; n++) begin
            int w, f;
            w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
            f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 35)) : -1;
            run_brew(2'($urandom_range(0, 2)), w, f, int'($urandom_range(0, 2)), falhou);
            if (falhou) do_reset();
            if ($urandom_range(0, 1) == 1) begin
                START = 1'($urandom_range(0, 1));
                TIPO  = 2'b11;
                STATUS = 2'($urandom_range(0, 3));
                stepc(V_ESP, "ocioso_rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
